if_fetch_unit: RTL and testbench

Instruction fetch stage of the RV32IM five-stage pipeline. It owns the program counter, issues read requests to instruction memory over the BUSYWAIT handshake, and produces the INSTRUCTION / PC / PC_PLUS_4 triple consumed by the IF/ID pipeline register. It absorbs memory wait states, hazard-unit stalls and EX-stage branch redirects, inserting NOP bubbles where required.

---
 rtl/if_fetch_unit_pkg.sv | 19 +
 rtl/if_fetch_unit_if.sv | 31 +++
 rtl/if_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: bubble encoding,
// default reset vector, FSM state encoding and address alignment helper.
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding at pc, results go to the pipeline
    HOLD  = 2'd1,  // word captured during a stall, memory idle
    DROP  = 2'd2   // redirect pending, outstanding request is discarded
  } fetch_state_t;

  // Instruction addresses are word aligned; low two bits are forced to zero.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory, the hazard
// unit, the EX-stage redirect and the IF/ID register.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic [31:0] PC_PLUS_4;
  logic        VALID;
  logic        FETCH_BUSY;

  // Fetch unit side.
  modport master (
    input  STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_READDATA, IMEM_BUSYWAIT,
    output IMEM_ADDR, IMEM_READ, INSTRUCTION, PC, PC_PLUS_4, VALID, FETCH_BUSY
  );

  // Surrounding pipeline and memory side.
  modport slave (
    output STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_READDATA, IMEM_BUSYWAIT,
    input  IMEM_ADDR, IMEM_READ, INSTRUCTION, PC, PC_PLUS_4, VALID, FETCH_BUSY
  );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the BUSYWAIT read handshake and
// produces registered INSTRUCTION/PC/PC_PLUS_4 with NOP bubbles on waits,
// stalls and redirects.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          CLK,
  input  logic          RESET,
  if_fetch_unit_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic [31:0]  pend_target_q, pend_target_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_pc4_q, out_pc4_d;
  logic         valid_q, valid_d;

  logic         imem_read;
  logic         complete;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;

  // Memory is idle only while a captured word waits out a stall; reset kills
  // any request in flight.
  assign imem_read = !RESET && (state_q != HOLD);
  assign complete  = imem_read && !bus.IMEM_BUSYWAIT;
  assign target    = align_word(bus.BRANCH_TARGET);
  assign pc_plus4  = pc_q + 32'd4;

  assign bus.IMEM_ADDR   = pc_q;
  assign bus.IMEM_READ   = imem_read;
  assign bus.FETCH_BUSY  = imem_read && bus.IMEM_BUSYWAIT;
  assign bus.INSTRUCTION = instr_q;
  assign bus.PC          = out_pc_q;
  assign bus.PC_PLUS_4   = out_pc4_q;
  assign bus.VALID       = valid_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; redirects take priority over stalls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (bus.BRANCH_TAKEN)         state_d = complete ? FETCH : DROP;
        else if (complete && bus.STALL) state_d = HOLD;
      end
      HOLD:    if (bus.BRANCH_TAKEN || !bus.STALL) state_d = FETCH;
      DROP:    if (complete) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Datapath next values: PC, hold buffer, pending target and stage outputs.
  // A bubble drives NOP with VALID low but keeps the PC pair unchanged.
  always_comb begin
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    pend_target_d = pend_target_q;
    instr_d       = instr_q;
    out_pc_d      = out_pc_q;
    out_pc4_d     = out_pc4_q;
    valid_d       = valid_q;
    case (state_q)
      FETCH: begin
        if (bus.BRANCH_TAKEN) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (complete) pc_d = target;
          else          pend_target_d = target;
        end else if (complete) begin
          pc_d = pc_plus4;
          if (bus.STALL) begin
            hold_instr_d = bus.IMEM_READDATA;
            hold_pc_d    = pc_q;
          end else begin
            instr_d   = bus.IMEM_READDATA;
            out_pc_d  = pc_q;
            out_pc4_d = pc_plus4;
            valid_d   = 1'b1;
          end
        end else if (!bus.STALL) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (bus.BRANCH_TAKEN) begin
          pc_d    = target;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (!bus.STALL) begin
          instr_d   = hold_instr_q;
          out_pc_d  = hold_pc_q;
          out_pc4_d = hold_pc_q + 32'd4;
          valid_d   = 1'b1;
        end
      end
      DROP: begin
        // The newest redirect wins, even in the cycle the old request retires.
        if (bus.BRANCH_TAKEN) pend_target_d = target;
        if (complete)         pc_d = bus.BRANCH_TAKEN ? target : pend_target_q;
        if (bus.BRANCH_TAKEN || !bus.STALL) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q          <= RESET_PC;
      hold_instr_q  <= NOP_INSTR;
      hold_pc_q     <= 32'd0;
      pend_target_q <= 32'd0;
      instr_q       <= NOP_INSTR;
      out_pc_q      <= 32'd0;
      out_pc4_q     <= 32'd0;
      valid_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      pend_target_q <= pend_target_d;
      instr_q       <= instr_d;
      out_pc_q      <= out_pc_d;
      out_pc4_q     <= out_pc4_d;
      valid_q       <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: two instances, one with the default reset
// vector and one resetting to the top word of the address space.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic CLK;
  logic RESET0;
  logic RESET1;
  int   pass_cnt;
  int   total_cnt;

  if_fetch_unit_if bus0 ();
  if_fetch_unit_if bus1 ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .CLK   (CLK),
    .RESET (RESET0),
    .bus   (bus0)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .CLK   (CLK),
    .RESET (RESET1),
    .bus   (bus1)
  );

  // Instruction memory: word content derived from its address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign bus0.IMEM_READDATA = memw(bus0.IMEM_ADDR);
  assign bus1.IMEM_READDATA = memw(bus1.IMEM_ADDR);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %-14s got %h", tag, got);
    end else begin
      $display("FAIL %-14s got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge CLK);
  endtask

  // Pipeline-side outputs of instance 0.
  task automatic chk_out0(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc, input logic valid);
    check({tag, ".instr"}, bus0.INSTRUCTION, instr);
    check({tag, ".pc"},    bus0.PC, pc);
    check({tag, ".pc4"},   bus0.PC_PLUS_4, pc + 32'd4);
    check({tag, ".valid"}, {31'd0, bus0.VALID}, {31'd0, valid});
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    RESET0 = 1'b1;
    RESET1 = 1'b1;
    bus0.STALL = 1'b0; bus0.BRANCH_TAKEN = 1'b0; bus0.BRANCH_TARGET = 32'd0; bus0.IMEM_BUSYWAIT = 1'b0;
    bus1.STALL = 1'b0; bus1.BRANCH_TAKEN = 1'b0; bus1.BRANCH_TARGET = 32'd0; bus1.IMEM_BUSYWAIT = 1'b0;
    step(); step();

    // Reset state.
    check("rst.instr", bus0.INSTRUCTION, NOP_INSTR);
    check("rst.pc",    bus0.PC, 32'd0);
    check("rst.pc4",   bus0.PC_PLUS_4, 32'd0);
    check("rst.valid", {31'd0, bus0.VALID}, 32'd0);
    check("rst.read",  {31'd0, bus0.IMEM_READ}, 32'd0);
    check("rst.addr",  bus0.IMEM_ADDR, 32'd0);

    // Zero-wait streaming.
    RESET0 = 1'b0;
    #1 check("run.read", {31'd0, bus0.IMEM_READ}, 32'd1);
    step(); chk_out0("s0", memw(32'h0), 32'h0, 1'b1);
    step(); chk_out0("s4", memw(32'h4), 32'h4, 1'b1);

    // Three wait cycles on 0x8.
    bus0.IMEM_BUSYWAIT = 1'b1;
    #1 check("w.busy", {31'd0, bus0.FETCH_BUSY}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out0($sformatf("wait%0d", i), NOP_INSTR, 32'h4, 1'b0);
      check($sformatf("wait%0d.addr", i), bus0.IMEM_ADDR, 32'h8);
    end
    bus0.IMEM_BUSYWAIT = 1'b0;
    step(); chk_out0("s8", memw(32'h8), 32'h8, 1'b1);

    // Stall on completion of 0xC for two cycles.
    bus0.STALL = 1'b1;
    step(); chk_out0("stl0", memw(32'h8), 32'h8, 1'b1);
    check("stl0.read", {31'd0, bus0.IMEM_READ}, 32'd0);
    check("stl0.addr", bus0.IMEM_ADDR, 32'h10);
    step(); chk_out0("stl1", memw(32'h8), 32'h8, 1'b1);
    check("stl1.read", {31'd0, bus0.IMEM_READ}, 32'd0);
    bus0.STALL = 1'b0;
    step(); chk_out0("sC", memw(32'hC), 32'hC, 1'b1);
    check("sC.addr", bus0.IMEM_ADDR, 32'h10);
    check("sC.read", {31'd0, bus0.IMEM_READ}, 32'd1);
    step(); chk_out0("s10", memw(32'h10), 32'h10, 1'b1);

    // Redirect to 0x103 while 0x14 is waiting.
    bus0.IMEM_BUSYWAIT = 1'b1;
    bus0.BRANCH_TAKEN  = 1'b1;
    bus0.BRANCH_TARGET = 32'h0000_0103;
    step(); chk_out0("drop0", NOP_INSTR, 32'h10, 1'b0);
    check("drop0.addr", bus0.IMEM_ADDR, 32'h14);
    check("drop0.read", {31'd0, bus0.IMEM_READ}, 32'd1);
    bus0.BRANCH_TAKEN = 1'b0;
    step(); chk_out0("drop1", NOP_INSTR, 32'h10, 1'b0);
    check("drop1.addr", bus0.IMEM_ADDR, 32'h14);
    bus0.IMEM_BUSYWAIT = 1'b0;
    step(); chk_out0("drop2", NOP_INSTR, 32'h10, 1'b0);
    check("drop2.addr", bus0.IMEM_ADDR, 32'h100);
    step(); chk_out0("s100", memw(32'h100), 32'h100, 1'b1);

    // Capture 0x104 under stall, then redirect with stall still high.
    bus0.STALL = 1'b1;
    step(); chk_out0("hold", memw(32'h100), 32'h100, 1'b1);
    check("hold.read", {31'd0, bus0.IMEM_READ}, 32'd0);
    bus0.BRANCH_TAKEN  = 1'b1;
    bus0.BRANCH_TARGET = 32'h0000_0200;
    step(); chk_out0("hbr", NOP_INSTR, 32'h100, 1'b0);
    check("hbr.addr", bus0.IMEM_ADDR, 32'h200);
    check("hbr.read", {31'd0, bus0.IMEM_READ}, 32'd1);
    bus0.BRANCH_TAKEN = 1'b0;
    bus0.STALL        = 1'b0;
    step(); chk_out0("s200", memw(32'h200), 32'h200, 1'b1);

    // Redirect in FETCH with zero-wait completion.
    bus0.BRANCH_TAKEN  = 1'b1;
    bus0.BRANCH_TARGET = 32'h0000_0040;
    step(); chk_out0("fbr", NOP_INSTR, 32'h200, 1'b0);
    check("fbr.addr", bus0.IMEM_ADDR, 32'h40);
    bus0.BRANCH_TAKEN = 1'b0;
    step(); chk_out0("s40", memw(32'h40), 32'h40, 1'b1);

    // Top-of-memory reset vector: wrap and reset during a wait.
    RESET1 = 1'b0;
    #1 check("t.addr0", bus1.IMEM_ADDR, 32'hFFFF_FFFC);
    check("t.read0", {31'd0, bus1.IMEM_READ}, 32'd1);
    step();
    check("t.pc",    bus1.PC, 32'hFFFF_FFFC);
    check("t.pc4",   bus1.PC_PLUS_4, 32'h0);
    check("t.instr", bus1.INSTRUCTION, memw(32'hFFFF_FFFC));
    check("t.addr1", bus1.IMEM_ADDR, 32'h0);
    bus1.IMEM_BUSYWAIT = 1'b1;
    step();
    check("t.busy",  {31'd0, bus1.FETCH_BUSY}, 32'd1);
    check("t.bub",   {31'd0, bus1.VALID}, 32'd0);
    RESET1 = 1'b1;
    #1 check("t.rstrd", {31'd0, bus1.IMEM_READ}, 32'd0);
    step();
    check("t.rpc",   bus1.PC, 32'h0);
    check("t.raddr", bus1.IMEM_ADDR, 32'hFFFF_FFFC);
    check("t.rval",  {31'd0, bus1.VALID}, 32'd0);
    RESET1 = 1'b0;
    bus1.IMEM_BUSYWAIT = 1'b0;
    step();
    check("t.pc2",   bus1.PC, 32'hFFFF_FFFC);
    check("t.val2",  {31'd0, bus1.VALID}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
